riscv_mem_arbiter: RTL and testbench

RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

---
 rtl/riscv_mem_arbiter_if.sv | 41 ++++
 rtl/riscv_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_arbiter_if.sv
// Bundle for the fetch port, data port and shared memory port of riscv_mem_arbiter.
// master: the arbiter's view; slave: the requesters' and memory's view.
interface riscv_mem_arbiter_if;
  logic        if_req;
  logic [29:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        dm_req;
  logic        dm_we;
  logic [29:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
    input  mem_ready, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
    output mem_ready, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory port, one transaction in flight,
// data-first priority with fetch starvation guard and a sticky response timeout.
module riscv_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic                       clk,
  input  logic                       rst_b,
  riscv_mem_arbiter_if.master        bus,
  output logic                       err
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TmoW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e              state_q, state_d;
  logic                owner_dm_q, owner_dm_d;
  logic [29:0]         addr_q, addr_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [StarveW-1:0]  starve_cnt_q, starve_cnt_d;
  logic [TmoW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic                err_q, err_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                dm_rvalid_q, dm_rvalid_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         dm_rdata_q, dm_rdata_d;

  logic grant_dm, grant_if, starved;

  // Fetch overrides data priority once it has waited out STARVE_LIMIT data grants.
  assign starved  = bus.if_req && (starve_cnt_q == StarveW'(STARVE_LIMIT));
  assign grant_dm = bus.dm_req && !starved;
  assign grant_if = bus.if_req && !grant_dm;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= StIdle;
      owner_dm_q   <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      starve_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      err_q        <= 1'b0;
      if_rvalid_q  <= 1'b0;
      dm_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_dm_q   <= owner_dm_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      starve_cnt_q <= starve_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      err_q        <= err_d;
      if_rvalid_q  <= if_rvalid_d;
      dm_rvalid_q  <= dm_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_dm_d   = owner_dm_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    starve_cnt_d = starve_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    err_d        = err_q;
    if_rvalid_d  = 1'b0;
    dm_rvalid_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (grant_dm) begin
          state_d    = StReq;
          owner_dm_d = 1'b1;
          addr_d     = bus.dm_addr;
          we_d       = bus.dm_we;
          wdata_d    = bus.dm_wdata;
          wstrb_d    = bus.dm_wstrb;
          if (!bus.if_req) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q != StarveW'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end else if (grant_if) begin
          state_d      = StReq;
          owner_dm_d   = 1'b0;
          addr_d       = bus.if_addr;
          we_d         = 1'b0;
          wdata_d      = '0;
          wstrb_d      = '0;
          starve_cnt_d = '0;
        end
      end
      StReq: begin
        if (bus.mem_ready) begin
          state_d   = StResp;
          tmo_cnt_d = '0;
        end
      end
      StResp: begin
        if (bus.mem_rvalid || (tmo_cnt_q == TmoW'(TIMEOUT - 1))) begin
          // A timed-out transaction completes to its owner with zero data.
          state_d = StIdle;
          err_d   = err_q || !bus.mem_rvalid;
          if (owner_dm_q) begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = bus.mem_rvalid ? bus.mem_rdata : 32'h0;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus.mem_rvalid ? bus.mem_rdata : 32'h0;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    // Grants are combinational, so they are gated by reset explicitly.
    bus.if_gnt    = rst_b && (state_q == StIdle) && grant_if;
    bus.dm_gnt    = rst_b && (state_q == StIdle) && grant_dm;
    bus.mem_req   = (state_q == StReq);
    bus.mem_we    = we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.mem_wstrb = wstrb_q;
    bus.if_rvalid = if_rvalid_q;
    bus.if_rdata  = if_rdata_q;
    bus.dm_rvalid = dm_rvalid_q;
    bus.dm_rdata  = dm_rdata_q;
    err           = err_q;
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Randomized bench for riscv_mem_arbiter against a transaction-level reference model.
module tb_riscv_mem_arbiter;

  localparam int unsigned StarveLimit = 4;
  localparam int unsigned Timeout     = 64;

  logic clk = 1'b0;
  logic rst_b;
  logic err;

  riscv_mem_arbiter_if bus();

  riscv_mem_arbiter #(
    .STARVE_LIMIT(StarveLimit),
    .TIMEOUT     (Timeout)
  ) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus),
    .err  (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int p_req, p_ready, p_rvalid;
  bit tmo_mode;

  // Reference model: one outstanding transaction and its lifecycle.
  bit          m_busy, m_acc, m_own_dm, m_we, m_err;
  logic [29:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  int unsigned m_wait, m_starve;
  bit          m_rv_if, m_rv_dm, m_dm_known;
  logic [31:0] m_if_rdata, m_dm_rdata;
  bit          exp_if_gnt, exp_dm_gnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit roll(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_own_dm = 0; m_we = 0; m_err = 0;
    m_addr = '0; m_wdata = '0; m_wstrb = '0;
    m_wait = 0; m_starve = 0;
    m_rv_if = 0; m_rv_dm = 0; m_dm_known = 1;
    m_if_rdata = '0; m_dm_rdata = '0;
    exp_if_gnt = 0; exp_dm_gnt = 0;
  endtask

  task automatic finish_txn(input logic [31:0] d);
    m_busy = 0;
    if (m_own_dm) begin
      m_rv_dm    = 1;
      m_dm_rdata = d;
      m_dm_known = !m_we;
    end else begin
      m_rv_if    = 1;
      m_if_rdata = d;
    end
  endtask

  // Advance the model across a rising edge using the inputs of the cycle just closed.
  task automatic model_step();
    m_rv_if = 0;
    m_rv_dm = 0;
    if (m_busy && m_acc) begin
      if (bus.mem_rvalid) begin
        finish_txn(bus.mem_rdata);
      end else begin
        m_wait++;
        if (m_wait == Timeout) begin
          m_err = 1;
          finish_txn(32'h0);
        end
      end
    end else if (m_busy) begin
      if (bus.mem_ready) begin
        m_acc  = 1;
        m_wait = 0;
      end
    end else if (exp_dm_gnt) begin
      m_busy = 1; m_acc = 0; m_own_dm = 1;
      m_addr = bus.dm_addr; m_we = bus.dm_we; m_wdata = bus.dm_wdata; m_wstrb = bus.dm_wstrb;
      if (!bus.if_req) m_starve = 0;
      else if (m_starve < StarveLimit) m_starve++;
    end else if (exp_if_gnt) begin
      m_busy = 1; m_acc = 0; m_own_dm = 0;
      m_addr = bus.if_addr; m_we = 0; m_wdata = '0; m_wstrb = '0;
      m_starve = 0;
    end
  endtask

  task automatic drive();
    if (!bus.if_req || exp_if_gnt) begin
      bus.if_req  = roll(p_req);
      bus.if_addr = 30'($urandom);
    end
    if (!bus.dm_req || exp_dm_gnt) begin
      bus.dm_req   = roll(p_req);
      bus.dm_we    = roll(50);
      bus.dm_addr  = 30'($urandom);
      bus.dm_wdata = $urandom;
      bus.dm_wstrb = 4'($urandom);
    end
    bus.mem_ready  = roll(p_ready);
    bus.mem_rvalid = tmo_mode ? !(m_busy && m_acc) : roll(p_rvalid);
    bus.mem_rdata  = $urandom;
  endtask

  task automatic check_outputs();
    bit exp_mem_req;
    exp_dm_gnt  = !m_busy && bus.dm_req && !(bus.if_req && m_starve == StarveLimit);
    exp_if_gnt  = !m_busy && bus.if_req && !exp_dm_gnt;
    exp_mem_req = m_busy && !m_acc;
    check("if_gnt", 32'(bus.if_gnt), 32'(exp_if_gnt));
    check("dm_gnt", 32'(bus.dm_gnt), 32'(exp_dm_gnt));
    check("mem_req", 32'(bus.mem_req), 32'(exp_mem_req));
    if (exp_mem_req) begin
      check("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
      check("mem_we", 32'(bus.mem_we), 32'(m_we));
      check("mem_wstrb", 32'(bus.mem_wstrb), 32'(m_wstrb));
      if (m_we) check("mem_wdata", bus.mem_wdata, m_wdata);
    end
    check("if_rvalid", 32'(bus.if_rvalid), 32'(m_rv_if));
    check("dm_rvalid", 32'(bus.dm_rvalid), 32'(m_rv_dm));
    check("if_rdata", bus.if_rdata, m_if_rdata);
    if (m_dm_known) check("dm_rdata", bus.dm_rdata, m_dm_rdata);
    check("err", 32'(err), 32'(m_err));
  endtask

  task automatic check_reset_state();
    check("rst_if_gnt", 32'(bus.if_gnt), 32'h0);
    check("rst_dm_gnt", 32'(bus.dm_gnt), 32'h0);
    check("rst_mem_req", 32'(bus.mem_req), 32'h0);
    check("rst_if_rvalid", 32'(bus.if_rvalid), 32'h0);
    check("rst_dm_rvalid", 32'(bus.dm_rvalid), 32'h0);
    check("rst_if_rdata", bus.if_rdata, 32'h0);
    check("rst_dm_rdata", bus.dm_rdata, 32'h0);
    check("rst_err", 32'(err), 32'h0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    drive();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n, input int pr, input int pa, input int pv, input bit tm);
    p_req = pr; p_ready = pa; p_rvalid = pv; tmo_mode = tm;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst_b          = 1'b0;
    bus.if_req     = 1'b1;
    bus.if_addr    = 30'h155;
    bus.dm_req     = 1'b1;
    bus.dm_we      = 1'b0;
    bus.dm_addr    = 30'h2aa;
    bus.dm_wdata   = 32'h0;
    bus.dm_wstrb   = 4'h0;
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hdeadbeef;
    model_reset();

    #12;
    check_reset_state();
    @(posedge clk);
    @(negedge clk);
    check_reset_state();
    rst_b = 1'b1;
    #1;
    check_outputs();

    run(600, 60, 70, 40, 1'b0);   // mixed traffic
    run(300, 100, 100, 100, 1'b0); // both ports saturated: starvation guard
    run(400, 70, 10, 50, 1'b0);   // long REQ stalls
    run(300, 60, 100, 0, 1'b1);   // timeouts with late responses outside RESP
    run(300, 60, 70, 40, 1'b0);   // err must stay set

    // Reset in the middle of a response wait.
    p_rvalid = 0;
    for (int i = 0; i < 300 && !(m_busy && m_acc); i++) cycle();
    check("reach_resp", 32'(m_busy && m_acc), 32'h1);
    #2;
    rst_b = 1'b0;
    #1;
    check_reset_state();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_reset_state();
    rst_b = 1'b1;
    #1;
    check_outputs();

    run(400, 60, 70, 40, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
